// File: rtl/lzc_normalizer.sv
// Sequential leading-zero counter / normaliser: a binary search over the word,
// one halving step per clock, producing the shift amount for the left barrel shifter.
module lzc_normalizer #(
  parameter int WIDTH      = 32,
  parameter int SHIFTWIDTH = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [WIDTH-1:0]      din,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [WIDTH-1:0]      norm_out,
  output logic [SHIFTWIDTH-1:0] shift_out,
  output logic                  zero,
  output logic                  out_valid,
  input  logic                  out_ready
);

  localparam int KW = (SHIFTWIDTH > 1) ? $clog2(SHIFTWIDTH) : 1;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_SCAN = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [1:0]            state_q, state_d;
  logic [WIDTH-1:0]      work_q, work_d;
  logic [SHIFTWIDTH-1:0] shift_q, shift_d;
  logic                  zero_q, zero_d;
  logic                  out_valid_q, out_valid_d;
  logic [KW-1:0]         k_q, k_d;

  // Per-step "top 2**k bits are zero" flags and the matching shifted word.
  logic [SHIFTWIDTH-1:0] top_zero;
  logic [WIDTH-1:0]      shifted [SHIFTWIDTH];

  genvar gi;
  generate
    for (gi = 0; gi < SHIFTWIDTH; gi++) begin : g_step
      localparam int SH = 1 << gi;
      assign top_zero[gi] = ~|work_q[WIDTH-1 -: SH];
      assign shifted[gi]  = {work_q[WIDTH-1-SH:0], {SH{1'b0}}};
    end
  endgenerate

  assign in_ready  = (state_q == ST_IDLE) && !rst;
  assign norm_out  = work_q;
  assign shift_out = shift_q;
  assign zero      = zero_q;
  assign out_valid = out_valid_q;

  always_comb begin
    state_d     = state_q;
    work_d      = work_q;
    shift_d     = shift_q;
    zero_d      = zero_q;
    out_valid_d = out_valid_q;
    k_d         = k_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid && in_ready) begin
          work_d  = din;
          shift_d = '0;
          zero_d  = (din == '0);
          k_d     = KW'(SHIFTWIDTH - 1);
          state_d = ST_SCAN;
        end
      end
      ST_SCAN: begin
        if (top_zero[k_q]) begin
          work_d       = shifted[k_q];
          shift_d[k_q] = 1'b1;
        end
        if (k_q == '0) begin
          state_d     = ST_DONE;
          out_valid_d = 1'b1;
        end else begin
          k_d = k_q - 1'b1;
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          state_d     = ST_IDLE;
          out_valid_d = 1'b0;
        end
      end
      default: begin
        state_d     = ST_IDLE;
        out_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      work_q      <= '0;
      shift_q     <= '0;
      zero_q      <= 1'b0;
      out_valid_q <= 1'b0;
      k_q         <= KW'(SHIFTWIDTH - 1);
    end else begin
      state_q     <= state_d;
      work_q      <= work_d;
      shift_q     <= shift_d;
      zero_q      <= zero_d;
      out_valid_q <= out_valid_d;
      k_q         <= k_d;
    end
  end

endmodule

// File: tb/tb_lzc_normalizer.sv
// Directed and randomised bench for lzc_normalizer: latency, handshake, reset and
// a reference leading-zero count plus barrel-shift cross-check.
module tb_lzc_normalizer;

  logic        clk;
  logic        rst;
  logic [31:0] din;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] norm_out;
  logic [4:0]  shift_out;
  logic        zero;
  logic        out_valid;
  logic        out_ready;

  int checks_cnt;
  int errors_cnt;

  lzc_normalizer #(.WIDTH(32), .SHIFTWIDTH(5)) dut (
    .clk       (clk),
    .rst       (rst),
    .din       (din),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .norm_out  (norm_out),
    .shift_out (shift_out),
    .zero      (zero),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks_cnt++;
    if (got !== exp) begin
      errors_cnt++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [4:0] ref_lzc(input logic [31:0] v);
    logic [4:0] n;
    n = 5'd31;
    for (int i = 31; i >= 0; i--) begin
      if (v[i]) begin
        n = 5'(31 - i);
        break;
      end
    end
    return n;
  endfunction

  task automatic accept(input logic [31:0] v);
    @(negedge clk);
    check("in_ready_idle", 32'(in_ready), 32'd1);
    din      = v;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    din      = $urandom;
  endtask

  // Accept, time the result, hold off the consumer for hold_cycles, then drain.
  task automatic run_vector(input logic [31:0] v, input logic [4:0] exp_shift,
                            input logic [31:0] exp_norm, input logic exp_zero,
                            input int hold_cycles, input bit verbose);
    int cnt;
    accept(v);
    cnt = 0;
    @(negedge clk);
    while (!out_valid && cnt < 20) begin
      @(negedge clk);
      cnt++;
    end
    check("latency", 32'(cnt), 32'd5);
    check("shift_out", 32'(shift_out), 32'(exp_shift));
    check("norm_out", norm_out, exp_norm);
    check("zero", 32'(zero), 32'(exp_zero));
    check("barrel_xchk", norm_out, v << shift_out);
    if (v != 0) check("norm_msb", 32'(norm_out[31]), 32'd1);
    check("in_ready_busy", 32'(in_ready), 32'd0);
    for (int i = 0; i < hold_cycles; i++) begin
      in_valid = 1'b1;
      din      = 32'h0000_0001;
      @(negedge clk);
      check("hold_valid", 32'(out_valid), 32'd1);
      check("hold_shift", 32'(shift_out), 32'(exp_shift));
      check("hold_norm", norm_out, exp_norm);
      check("hold_in_ready", 32'(in_ready), 32'd0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    @(negedge clk);
    check("valid_drop", 32'(out_valid), 32'd0);
    check("in_ready_back", 32'(in_ready), 32'd1);
    check("retain_norm", norm_out, exp_norm);
    check("retain_shift", 32'(shift_out), 32'(exp_shift));
    if (verbose)
      $display("txn din=0x%08h shift=%0d norm=0x%08h zero=%0d", v, shift_out, norm_out, zero);
  endtask

  initial begin
    logic [31:0] r;
    checks_cnt = 0;
    errors_cnt = 0;
    rst        = 1'b1;
    din        = '0;
    in_valid   = 1'b0;
    out_ready  = 1'b0;
    #3;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_shift", 32'(shift_out), 32'd0);
    check("rst_norm", norm_out, 32'd0);
    check("rst_zero", 32'(zero), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    $display("txn reset released");

    run_vector(32'h0000_1111, 5'd19, 32'h8888_0000, 1'b0, 0, 1'b1);
    run_vector(32'h8000_0000, 5'd0,  32'h8000_0000, 1'b0, 0, 1'b1);
    run_vector(32'h0000_0001, 5'd31, 32'h8000_0000, 1'b0, 0, 1'b1);
    run_vector(32'h0000_0000, 5'd31, 32'h0000_0000, 1'b1, 0, 1'b1);
    run_vector(32'h0000_FFFF, 5'd16, 32'hFFFF_0000, 1'b0, 10, 1'b1);

    // Reset two cycles into a scan; the in-flight result is lost.
    accept(32'h00F0_0000);
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("midrst_valid", 32'(out_valid), 32'd0);
    check("midrst_shift", 32'(shift_out), 32'd0);
    check("midrst_norm", norm_out, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("midrst_in_ready", 32'(in_ready), 32'd1);
    check("midrst_shift_rel", 32'(shift_out), 32'd0);
    $display("txn mid-scan reset done");
    run_vector(32'h00F0_0000, 5'd8, 32'hF000_0000, 1'b0, 0, 1'b1);

    for (int i = 0; i < 1000; i++) begin
      r = $urandom >> $urandom_range(0, 31);
      run_vector(r, ref_lzc(r), r << ref_lzc(r), (r == 0), 0, 1'b1);
    end

    $display("CHECKS %0d ERRORS %0d", checks_cnt, errors_cnt);
    $finish;
  end

endmodule
